prefetch_fetch_ctrl: RTL

Upstream feeder for the 8-entry prefetch buffer. Generates sequential instruction addresses and issues them to instruction memory over a valid/ready request channel. Accepts in-order responses and writes each returned word, tagged with its PC, into the buffer. On redirect it flushes the buffer and discards responses still in flight.

---
 rtl/prefetch_fetch_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prefetch_fetch_ctrl.sv
// Sequential instruction fetcher feeding the prefetch buffer; 1-cycle response-to-write latency.
// Requests throttled by credit (occupancy + in-flight + pending write); redirect flushes and drains stale responses.
module prefetch_fetch_ctrl #(
  parameter int          DEPTH           = 8,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic [3:0]  buf_count,
  output logic        buf_write_enable,
  output logic [31:0] buf_write_data,
  output logic [31:0] buf_write_pc,
  output logic        buf_flush,
  output logic [1:0]  outstanding
);

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);
  localparam logic [5:0] DEPTH_W = 6'(DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] wr_pc_q, wr_pc_d;
  logic        flush_q, flush_d;
  // Holds request valid low from reset assertion until the first edge after release.
  logic        run_q;

  logic [5:0]  credit_sum;
  logic        req_vld;
  logic        accept;
  logic        resp_ok;

  assign credit_sum = {2'b00, buf_count} + {4'b0000, outstanding_q} + {5'b00000, wr_en_q};
  assign req_vld    = run_q && (state_q == FETCH) && (outstanding_q < MAX_OUT)
                      && (credit_sum < DEPTH_W);
  assign accept     = req_vld && mem_req_ready;
  // A response with nothing in flight is a protocol error and is ignored.
  assign resp_ok    = mem_resp_valid && (outstanding_q != 2'd0);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    wr_pc_d       = wr_pc_q;
    flush_d       = 1'b0;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, resp_ok};

    if (redirect) begin
      // Everything accepted or answered up to and including this cycle is stale.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      flush_d    = 1'b1;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != 2'd0) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          if (resp_ok) begin
            wr_en_d   = 1'b1;
            wr_data_d = mem_resp_data;
            wr_pc_d   = resp_pc_q;
            resp_pc_d = resp_pc_q + 32'd4;
          end
        end
        DRAIN: begin
          if (resp_ok) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
            if (drop_cnt_q == 2'd1) begin
              state_d = FETCH;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 32'd0;
      wr_pc_q       <= 32'd0;
      flush_q       <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      wr_pc_q       <= wr_pc_d;
      flush_q       <= flush_d;
      run_q         <= 1'b1;
    end
  end

  assign mem_req_valid    = req_vld;
  assign mem_req_addr     = fetch_pc_q;
  assign buf_write_enable = wr_en_q;
  assign buf_write_data   = wr_data_q;
  assign buf_write_pc     = wr_pc_q;
  assign buf_flush        = flush_q;
  assign outstanding      = outstanding_q;

endmodule
